// File: rtl/basemul_acc.sv
// basemul_acc: Kyber NTT-domain basemul over k polynomial pairs,
// accumulated in RAM, optional tomont, streamed out pairwise.
module basemul_acc #(
   parameter int DEPTH = 8,
   parameter int KMAX  = 4,
   parameter int KW    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [KW-1:0]      k_num,
   input  logic               tomont,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] in_a0,
   input  logic signed [15:0] in_a1,
   input  logic signed [15:0] in_b0,
   input  logic signed [15:0] in_b1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_c0,
   output logic signed [15:0] out_c1,
   output logic [DEPTH-1:0]   out_index,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int JW = DEPTH - 1;
   localparam logic [JW-1:0] JMAX = '1;

   localparam logic signed [15:0] ZETA [64] = '{
      -16'sd1103,  16'sd430,   16'sd555,   16'sd843,
      -16'sd1251,  16'sd871,   16'sd1550,  16'sd105,
       16'sd422,   16'sd587,   16'sd177,  -16'sd235,
      -16'sd291,  -16'sd460,   16'sd1574,  16'sd1653,
      -16'sd246,   16'sd778,   16'sd1159, -16'sd147,
      -16'sd777,   16'sd1483, -16'sd602,   16'sd1119,
      -16'sd1590,  16'sd644,  -16'sd872,   16'sd349,
       16'sd418,   16'sd329,  -16'sd156,  -16'sd75,
       16'sd817,   16'sd1097,  16'sd603,   16'sd610,
       16'sd1322, -16'sd1285, -16'sd1465,  16'sd384,
      -16'sd1215, -16'sd136,   16'sd1218, -16'sd1335,
      -16'sd874,   16'sd220,  -16'sd1187, -16'sd1659,
      -16'sd1185, -16'sd1530, -16'sd1278,  16'sd794,
      -16'sd1510, -16'sd854,  -16'sd870,   16'sd478,
      -16'sd108,  -16'sd308,   16'sd996,   16'sd991,
       16'sd958,  -16'sd1460,  16'sd1522,  16'sd1628
   };

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

   // t only needs its low 16 bits, so the multiply can stay unsigned
   function automatic logic signed [15:0] mred(
      input logic signed [31:0] x
   );
      logic [15:0]        tl;
      logic signed [31:0] t32;
      logic signed [31:0] d;
      tl  = x[15:0] * 16'hF301;
      t32 = $signed({{16{tl[15]}}, tl});
      d   = x - t32 * 32'sd3329;
      return d[31:16];
   endfunction

   function automatic logic signed [15:0] fqmul(
      input logic signed [15:0] a,
      input logic signed [15:0] b
   );
      logic signed [31:0] p;
      p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
      return mred(p);
   endfunction

   function automatic logic signed [15:0] barrett(
      input logic signed [15:0] a
   );
      logic signed [31:0] a32;
      logic signed [31:0] v;
      a32 = $signed({{16{a[15]}}, a});
      v   = (a32 * 32'sd20159 + 32'sd33554432) >>> 26;
      a32 = a32 - v * 32'sd3329;
      return a32[15:0];
   endfunction

   state_t st, nx;

   logic [KW-1:0] k_lat;
   logic [KW-1:0] p_cnt;
   logic          tm_lat;
   logic [JW-1:0] j_cnt;
   logic [JW-1:0] rd_j;
   logic          rd_left;

   logic start_ok;
   logic hs_in;
   logic last_in;
   logic pipe_busy;
   logic issue;

   logic signed [15:0] acc0 [1 << JW];
   logic signed [15:0] acc1 [1 << JW];

   logic               s1_v, s2_v, s3_v;
   logic               s1_first, s2_first, s3_first;
   logic [JW-1:0]      s1_j, s2_j, s3_j;
   logic signed [15:0] s1_a0, s1_a1, s1_b0, s1_b1, s1_z;
   logic signed [15:0] s2_m00, s2_m11, s2_m01, s2_m10, s2_z;
   logic signed [15:0] s3_t0, s3_t1, s3_r0, s3_r1;

   logic [5:0]         z_idx;
   logic signed [15:0] z_sel;
   logic signed [15:0] w0, w1;
   logic signed [15:0] rd0, rd1, cv0, cv1;

   assign start_ok  = start && (k_num != '0) &&
                      (k_num <= KW'(KMAX));
   assign in_ready  = (st == LOAD);
   assign busy      = (st != IDLE);
   assign hs_in     = in_valid & in_ready;
   assign last_in   = hs_in && (j_cnt == JMAX) &&
                      (p_cnt == k_lat - KW'(1));
   assign pipe_busy = s1_v | s2_v | s3_v;
   assign issue     = (st == OUT) && rd_left &&
                      (!out_valid || out_ready);
   assign done      = out_valid && out_ready &&
                      (out_index == {JMAX, 1'b0});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st <= IDLE;
      else        st <= nx;
   end

   always_comb begin
      nx = st;
      unique case (st)
         IDLE:    if (start_ok)   nx = LOAD;
         LOAD:    if (last_in)    nx = DRAIN;
         DRAIN:   if (!pipe_busy) nx = OUT;
         OUT:     if (done)       nx = IDLE;
         default:                 nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k_lat   <= '0;
         tm_lat  <= 1'b0;
         j_cnt   <= '0;
         p_cnt   <= '0;
         rd_j    <= '0;
         rd_left <= 1'b0;
         err     <= 1'b0;
      end else begin
         err <= (st == IDLE) && start && !start_ok;
         if ((st == IDLE) && start_ok) begin
            k_lat   <= k_num;
            tm_lat  <= tomont;
            j_cnt   <= '0;
            p_cnt   <= '0;
            rd_j    <= '0;
            rd_left <= 1'b1;
         end else begin
            if (hs_in) begin
               j_cnt <= j_cnt + 1'b1;
               if (j_cnt == JMAX) p_cnt <= p_cnt + 1'b1;
            end
            if (issue) begin
               rd_j <= rd_j + 1'b1;
               if (rd_j == JMAX) rd_left <= 1'b0;
            end
         end
      end
   end

   // odd pairs use the negated zeta of their even neighbour
   always_comb begin
      z_idx = 6'(j_cnt >> 1);
      z_sel = j_cnt[0] ? -ZETA[z_idx] : ZETA[z_idx];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s3_v <= 1'b0;
      end else begin
         s1_v <= hs_in;
         s2_v <= s1_v;
         s3_v <= s2_v;
      end
   end

   always_ff @(posedge clk) begin
      if (hs_in) begin
         s1_first <= (p_cnt == '0);
         s1_j     <= j_cnt;
         s1_a0    <= in_a0;
         s1_a1    <= in_a1;
         s1_b0    <= in_b0;
         s1_b1    <= in_b1;
         s1_z     <= z_sel;
      end
      if (s1_v) begin
         s2_first <= s1_first;
         s2_j     <= s1_j;
         s2_m00   <= fqmul(s1_a0, s1_b0);
         s2_m11   <= fqmul(s1_a1, s1_b1);
         s2_m01   <= fqmul(s1_a0, s1_b1);
         s2_m10   <= fqmul(s1_a1, s1_b0);
         s2_z     <= s1_z;
      end
      if (s2_v) begin
         s3_first <= s2_first;
         s3_j     <= s2_j;
         s3_t0    <= fqmul(s2_m11, s2_z) + s2_m00;
         s3_t1    <= s2_m01 + s2_m10;
         s3_r0    <= acc0[s2_j];
         s3_r1    <= acc1[s2_j];
      end
   end

   // first pass overwrites, so no clear sweep is needed
   always_comb begin
      w0 = s3_first ? s3_t0 : barrett(s3_r0 + s3_t0);
      w1 = s3_first ? s3_t1 : barrett(s3_r1 + s3_t1);
   end

   always_ff @(posedge clk) begin
      if (s3_v) begin
         acc0[s3_j] <= w0;
         acc1[s3_j] <= w1;
      end
   end

   always_comb begin
      rd0 = acc0[rd_j];
      rd1 = acc1[rd_j];
      cv0 = tm_lat ? fqmul(rd0, 16'sd1353) : rd0;
      cv1 = tm_lat ? fqmul(rd1, 16'sd1353) : rd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_c0    <= '0;
         out_c1    <= '0;
         out_index <= '0;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_c0    <= cv0;
         out_c1    <= cv1;
         out_index <= {rd_j, 1'b0};
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_c0    <= '0;
         out_c1    <= '0;
         out_index <= '0;
      end
   end

endmodule

// File: tb/tb_basemul_acc.sv
// tb_basemul_acc: directed bench for basemul_acc with an integer
// reference of the Kyber basemul/accumulate/tomont arithmetic.
module tb_basemul_acc;

   localparam int NP = 128;
   localparam int Q  = 3329;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [2:0]         k_num;
   logic               tomont;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_a0, in_a1, in_b0, in_b1;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_c0, out_c1;
   logic [7:0]         out_index;
   logic               busy, done, err;

   int total = 0;
   int bad   = 0;
   int macc0 [NP];
   int macc1 [NP];

   int zt [64] = '{
      -1103,  430,  555,  843, -1251,  871,  1550,  105,
        422,  587,  177, -235,  -291, -460,  1574, 1653,
       -246,  778, 1159, -147,  -777, 1483,  -602, 1119,
      -1590,  644, -872,  349,   418,  329,  -156,  -75,
        817, 1097,  603,  610,  1322, -1285, -1465, 384,
      -1215, -136, 1218, -1335, -874,  220, -1187, -1659,
      -1185, -1530, -1278, 794, -1510, -854, -870,  478,
       -108, -308,  996,  991,   958, -1460, 1522, 1628
   };

   basemul_acc #(.DEPTH(8), .KMAX(4), .KW(3)) dut (
      .clk(clk), .reset(reset), .start(start), .k_num(k_num),
      .tomont(tomont), .in_valid(in_valid), .in_ready(in_ready),
      .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_c0(out_c0), .out_c1(out_c1), .out_index(out_index),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int s16(int x);
      return int'(shortint'(x));
   endfunction

   function automatic int mred(int x);
      shortint t;
      t = shortint'(x * (-3327));
      return (x - int'(t) * Q) >>> 16;
   endfunction

   function automatic int fq(int a, int b);
      return mred(a * b);
   endfunction

   function automatic int bar(int a);
      int v;
      v = (20159 * a + (1 << 25)) >>> 26;
      return s16(a - v * Q);
   endfunction

   function automatic int modq(int x);
      return ((x % Q) + Q) % Q;
   endfunction

   task automatic chk(input string tag,
                      input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic gen(input int pat, input int p, input int j,
                      output int a0, output int a1,
                      output int b0, output int b1);
      if (pat == 0) begin
         a0 = 2; a1 = 0; b0 = 3; b1 = 5;
      end else if (pat == 1) begin
         a0 = 0; a1 = 1; b0 = 0; b1 = 1;
      end else begin
         a0 = ((j * 97 + p * 13) % Q) - 1664;
         a1 = ((j * 211 + p * 7 + 5) % Q) - 1664;
         b0 = ((j * 53 + p * 29 + 100) % Q) - 1664;
         b1 = ((j * 173 + p * 31 + 7) % Q) - 1664;
      end
   endtask

   task automatic model_pair(input int p, input int j,
                             input int a0, input int a1,
                             input int b0, input int b1);
      int z, t0, t1;
      z = zt[j >> 1];
      if (j % 2 == 1) z = -z;
      t0 = s16(fq(fq(a1, b1), z) + fq(a0, b0));
      t1 = s16(fq(a0, b1) + fq(a1, b0));
      if (p == 0) begin
         macc0[j] = t0;
         macc1[j] = t1;
      end else begin
         macc0[j] = bar(s16(macc0[j] + t0));
         macc1[j] = bar(s16(macc1[j] + t1));
      end
   endtask

   task automatic bad_start(input int k);
      @(negedge clk);
      start = 1'b1; k_num = 3'(k);
      #1;
      chk("err_pre", err, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("err_pulse", err, 1);
      chk("busy_rej", busy, 0);
      @(negedge clk);
      #1;
      chk("err_clear", err, 0);
      chk("busy_rej2", busy, 0);
   endtask

   task automatic do_start(input int k, input bit tm);
      @(negedge clk);
      start = 1'b1; k_num = 3'(k); tomont = tm;
      #1;
      chk("busy_pre", busy, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("busy_go", busy, 1);
      chk("ready_go", in_ready, 1);
      chk("err_go", err, 0);
   endtask

   task automatic load(input int k, input int pat, input bit gaps,
                       input int lim, input bit probe);
      int n, cyc, p, j, a0, a1, b0, b1;
      bit v;
      n = 0; cyc = 0;
      while (n < lim && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         p = n / NP; j = n % NP;
         gen(pat, p, j, a0, a1, b0, b1);
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_valid = v;
         in_a0 = 16'(a0); in_a1 = 16'(a1);
         in_b0 = 16'(b0); in_b1 = 16'(b1);
         if (probe && cyc == 20) begin
            start = 1'b1; k_num = 3'd2;
         end else begin
            start = 1'b0;
         end
         #1;
         chk("busy_load", busy, 1);
         chk("ready_load", in_ready, 1);
         if (probe && cyc == 21) chk("err_probe", err, 0);
         if (v) begin
            model_pair(p, j, a0, a1, b0, b1);
            n++;
         end
      end
      if (n < lim) chk("load_timeout", n, lim);
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0;
      #1;
      if (lim == k * NP) chk("ready_drop", in_ready, 0);
   endtask

   task automatic unload(input bit tm, input bit bp, input bit junk,
                         input int cm, input int r0, input int r1);
      int e, cyc, dn, fc, lc, x0, x1, v0, z, s;
      bit rdy;
      e = 0; cyc = 0; dn = 0; fc = -1; lc = -1;
      while (e < NP && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         rdy = bp ? (cyc % 2 == 1) : 1'b1;
         out_ready = rdy;
         if (junk) begin
            in_valid = 1'b1;
            in_a0 = 16'sd777; in_a1 = -16'sd5;
            in_b0 = 16'sd1200; in_b1 = 16'sd31;
         end
         #1;
         chk("busy_out", busy, 1);
         if (out_valid) begin
            if (fc < 0) fc = cyc;
            lc = cyc;
            x0 = tm ? fq(macc0[e], 1353) : macc0[e];
            x1 = tm ? fq(macc1[e], 1353) : macc1[e];
            v0 = out_c0;
            chk("out_index", out_index, 2 * e);
            chk("out_c0", out_c0, x0);
            chk("out_c1", out_c1, x1);
            chk("done", done, (rdy && e == NP - 1));
            chk("range_c0", (v0 > -Q && v0 < Q), 1);
            if (cm == 1) begin
               chk("cong_c0", modq(out_c0), modq(r0));
               chk("cong_c1", modq(out_c1), modq(r1));
            end
            if (cm == 2) begin
               z = zt[e >> 1];
               s = (e % 2 == 0) ? 1 : -1;
               chk("cong_z0",
                   modq(v0 * (tm ? 65536 : 1353) - s * z), 0);
               chk("cong_z1", modq(out_c1), 0);
            end
            if (rdy) begin
               dn += int'(done);
               e++;
            end
         end else begin
            chk("idle_zero", |{out_c0, out_c1, out_index}, 0);
            chk("done_idle", done, 0);
         end
      end
      if (e < NP) chk("out_timeout", e, NP);
      else if (!bp) chk("tput", lc - fc + 1, NP);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      #1;
      chk("busy_end", busy, 0);
      chk("done_once", dn, 1);
      chk("valid_end", out_valid, 0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; k_num = '0; tomont = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_data", |{out_c0, out_c1, out_index}, 0);
      reset = 1'b1;

      bad_start(0);
      bad_start(5);

      do_start(1, 1'b1);
      load(1, 0, 1'b0, NP, 1'b0);
      unload(1'b1, 1'b0, 1'b0, 1, 6, 10);

      do_start(3, 1'b1);
      load(3, 0, 1'b0, 3 * NP, 1'b1);
      unload(1'b1, 1'b0, 1'b1, 1, 18, 30);

      do_start(1, 1'b1);
      load(1, 1, 1'b0, NP, 1'b0);
      unload(1'b1, 1'b0, 1'b0, 2, 0, 0);

      do_start(1, 1'b0);
      load(1, 1, 1'b0, NP, 1'b0);
      unload(1'b0, 1'b0, 1'b0, 2, 0, 0);

      do_start(3, 1'b1);
      load(3, 0, 1'b1, 3 * NP, 1'b0);
      unload(1'b1, 1'b1, 1'b0, 1, 18, 30);

      do_start(2, 1'b0);
      load(2, 2, 1'b1, 2 * NP, 1'b0);
      unload(1'b0, 1'b1, 1'b0, 0, 0, 0);

      do_start(2, 1'b0);
      load(2, 2, 1'b0, 40, 1'b0);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_ready", in_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      chk("abort_data", |{out_c0, out_c1, out_index}, 0);
      @(negedge clk);
      reset = 1'b1;

      do_start(1, 1'b1);
      load(1, 0, 1'b0, NP, 1'b0);
      unload(1'b1, 1'b0, 1'b0, 1, 6, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
